// File: rtl/host_mem_loader.sv
// Host command engine: bulk-loads imem/dmem from a valid/ready word stream,
// reads dmem back over a response channel, and owns the core's reset line.
module host_mem_loader #(
   parameter int IMEM_AW     = 9,
   parameter int DMEM_AW     = 8,
   parameter int LEN_W       = 10,
   parameter int DMEM_RD_LAT = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [31:0]        cmd_data,
   output logic               resp_valid,
   input  logic               resp_ready,
   output logic [31:0]        resp_data,
   output logic               busy,
   output logic               cpu_rst,
   output logic               write_to_imem,
   output logic [IMEM_AW-1:0] addr_imem_host,
   output logic [31:0]        data_imem_host,
   output logic               write_to_dmem,
   output logic [DMEM_AW-1:0] addr_dmem_host,
   output logic [31:0]        data_dmem_host,
   output logic               read_req_dmem,
   input  logic [31:0]        data_out_dmem
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LOAD    = 3'd1;
   localparam logic [2:0] S_RD_REQ  = 3'd2;
   localparam logic [2:0] S_RD_WAIT = 3'd3;
   localparam logic [2:0] S_RD_RESP = 3'd4;

   localparam logic [1:0] OP_LOAD_IMEM = 2'b00;
   localparam logic [1:0] OP_READ_DMEM = 2'b10;
   localparam logic [1:0] OP_RUN       = 2'b11;

   localparam logic [2:0]       RD_LAT  = 3'(DMEM_RD_LAT);
   localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

   logic [2:0]         r_state;
   logic [1:0]         r_op;
   logic [IMEM_AW-1:0] r_addr;
   logic [LEN_W-1:0]   r_cnt;
   logic [2:0]         r_lat;
   logic               r_cpu_rst;
   logic               r_wr_imem;
   logic [IMEM_AW-1:0] r_addr_imem;
   logic [31:0]        r_data_imem;
   logic               r_wr_dmem;
   logic [DMEM_AW-1:0] r_addr_dmem;
   logic [31:0]        r_data_dmem;
   logic               r_rd_req;
   logic               r_resp_valid;
   logic [31:0]        r_resp_data;

   logic               w_cmd_fire;
   logic               w_resp_fire;
   logic [1:0]         w_hdr_op;
   logic [LEN_W-1:0]   w_hdr_len;
   logic               w_unused;

   assign w_hdr_op    = cmd_data[31:30];
   assign w_hdr_len   = cmd_data[16+LEN_W-1:16];
   assign cmd_ready   = !rst && (r_state == S_IDLE || r_state == S_LOAD);
   assign w_cmd_fire  = cmd_valid && cmd_ready;
   assign w_resp_fire = r_resp_valid && resp_ready;
   // Reserved header bits are deliberately ignored.
   assign w_unused    = &{1'b0, cmd_data[29:16+LEN_W], cmd_data[15:IMEM_AW]};

   // NOTE: every register here is written with <= so all of them see the
   // pre-edge values of each other, exactly like the flops they become.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_op         <= OP_LOAD_IMEM;
         r_addr       <= '0;
         r_cnt        <= '0;
         r_lat        <= '0;
         r_cpu_rst    <= 1'b1;
         r_wr_imem    <= 1'b0;
         r_addr_imem  <= '0;
         r_data_imem  <= '0;
         r_wr_dmem    <= 1'b0;
         r_addr_dmem  <= '0;
         r_data_dmem  <= '0;
         r_rd_req     <= 1'b0;
         r_resp_valid <= 1'b0;
         r_resp_data  <= '0;
      end else begin
         r_wr_imem <= 1'b0;
         r_wr_dmem <= 1'b0;
         r_rd_req  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_cmd_fire) begin
                  if (w_hdr_op == OP_RUN) begin
                     r_cpu_rst <= ~cmd_data[0];
                  end else begin
                     r_cpu_rst <= 1'b1;
                     r_op      <= w_hdr_op;
                     r_addr    <= cmd_data[IMEM_AW-1:0];
                     r_cnt     <= w_hdr_len;
                     if (w_hdr_len != '0)
                        r_state <= (w_hdr_op == OP_READ_DMEM) ? S_RD_REQ : S_LOAD;
                  end
               end
            end
            S_LOAD: begin
               if (w_cmd_fire) begin
                  if (r_op == OP_LOAD_IMEM) begin
                     r_wr_imem   <= 1'b1;
                     r_addr_imem <= r_addr;
                     r_data_imem <= cmd_data;
                  end else begin
                     r_wr_dmem   <= 1'b1;
                     r_addr_dmem <= r_addr[DMEM_AW-1:0];
                     r_data_dmem <= cmd_data;
                  end
                  // Wraps at 2^IMEM_AW; dmem only sees the low bits, so it wraps too.
                  r_addr <= r_addr + 1'b1;
                  r_cnt  <= r_cnt - 1'b1;
                  if (r_cnt == CNT_ONE)
                     r_state <= S_IDLE;
               end
            end
            S_RD_REQ: begin
               r_rd_req    <= 1'b1;
               r_addr_dmem <= r_addr[DMEM_AW-1:0];
               r_lat       <= '0;
               r_state     <= S_RD_WAIT;
            end
            S_RD_WAIT: begin
               // r_lat reaches RD_LAT in the cycle the memory data is valid.
               if (r_lat == RD_LAT) begin
                  r_resp_data  <= data_out_dmem;
                  r_resp_valid <= 1'b1;
                  r_state      <= S_RD_RESP;
               end else begin
                  r_lat <= r_lat + 1'b1;
               end
            end
            S_RD_RESP: begin
               if (w_resp_fire) begin
                  r_resp_valid <= 1'b0;
                  r_addr       <= r_addr + 1'b1;
                  r_cnt        <= r_cnt - 1'b1;
                  r_state      <= (r_cnt == CNT_ONE) ? S_IDLE : S_RD_REQ;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy           = (r_state != S_IDLE);
   assign cpu_rst        = r_cpu_rst;
   assign write_to_imem  = r_wr_imem;
   assign addr_imem_host = r_addr_imem;
   assign data_imem_host = r_data_imem;
   assign write_to_dmem  = r_wr_dmem;
   assign addr_dmem_host = r_addr_dmem;
   assign data_dmem_host = r_data_dmem;
   assign read_req_dmem  = r_rd_req;
   assign resp_valid     = r_resp_valid;
   assign resp_data      = r_resp_data;

endmodule

// File: tb/tb_host_mem_loader.sv
// Randomized scoreboard bench for host_mem_loader: stimulus pushes expected
// memory events, a negedge monitor pops and compares them as they appear.
module tb_host_mem_loader;

   localparam int IMEM_AW = 9;
   localparam int DMEM_AW = 8;
   localparam int LEN_W   = 10;
   localparam int LAT     = 1;
   localparam int IMEM_D  = 1 << IMEM_AW;
   localparam int DMEM_D  = 1 << DMEM_AW;

   logic               clk;
   logic               rst;
   logic               cmd_valid;
   logic               cmd_ready;
   logic [31:0]        cmd_data;
   logic               resp_valid;
   logic               resp_ready;
   logic [31:0]        resp_data;
   logic               busy;
   logic               cpu_rst;
   logic               write_to_imem;
   logic [IMEM_AW-1:0] addr_imem_host;
   logic [31:0]        data_imem_host;
   logic               write_to_dmem;
   logic [DMEM_AW-1:0] addr_dmem_host;
   logic [31:0]        data_dmem_host;
   logic               read_req_dmem;
   logic [31:0]        data_out_dmem;

   host_mem_loader #(
      .IMEM_AW(IMEM_AW), .DMEM_AW(DMEM_AW), .LEN_W(LEN_W), .DMEM_RD_LAT(LAT)
   ) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .busy(busy), .cpu_rst(cpu_rst),
      .write_to_imem(write_to_imem), .addr_imem_host(addr_imem_host),
      .data_imem_host(data_imem_host),
      .write_to_dmem(write_to_dmem), .addr_dmem_host(addr_dmem_host),
      .data_dmem_host(data_dmem_host),
      .read_req_dmem(read_req_dmem), .data_out_dmem(data_out_dmem)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Physical dmem attached to the DUT; data is only valid LAT cycles after a request.
   logic [31:0] phys_dmem [DMEM_D];
   logic [31:0] pipe_d [LAT];
   logic        pipe_v [LAT];
   logic [31:0] junk;

   initial begin
      for (int i = 0; i < DMEM_D; i++) phys_dmem[i] = '0;
      for (int i = 0; i < LAT; i++) begin pipe_v[i] = 1'b0; pipe_d[i] = '0; end
      junk = '0;
   end

   always @(posedge clk) begin
      if (write_to_dmem === 1'b1) phys_dmem[addr_dmem_host] <= data_dmem_host;
      pipe_v[0] <= (read_req_dmem === 1'b1);
      pipe_d[0] <= phys_dmem[addr_dmem_host];
      for (int i = 1; i < LAT; i++) begin
         pipe_v[i] <= pipe_v[i-1];
         pipe_d[i] <= pipe_d[i-1];
      end
      junk <= $urandom;
   end

   assign data_out_dmem = pipe_v[LAT-1] ? pipe_d[LAT-1] : junk;

   // Reference model and scoreboard
   typedef enum int {EV_WI = 1, EV_WD = 2, EV_RQ = 3, EV_RS = 4} ev_kind_t;
   typedef struct {
      ev_kind_t    kind;
      int unsigned addr;
      logic [31:0] data;
   } ev_t;

   ev_t         exp_q [$];
   logic [31:0] model_dmem [DMEM_D];
   logic [31:0] pend_words [$];
   logic        model_cpu_rst;
   int          n_vec = 0;
   int          n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic mon_event(input ev_kind_t kind, input int unsigned addr, input logic [31:0] data);
      ev_t e;
      if (exp_q.size() == 0) begin
         n_vec++;
         n_err++;
         $display("FAIL unexpected_event: got kind %0d addr %0d data %h expected none (t=%0t)",
                  kind, addr, data, $time);
      end else begin
         e = exp_q.pop_front();
         check("event_kind", 32'(kind), 32'(e.kind));
         if (kind != EV_RS) check("event_addr", addr, e.addr);
         if (kind != EV_RQ) check("event_data", data, e.data);
      end
   endtask

   logic [31:0] prev_resp;
   logic        prev_stall = 1'b0;

   always @(negedge clk) begin
      int n_str;
      n_str = 0;
      if (write_to_imem === 1'b1) n_str++;
      if (write_to_dmem === 1'b1) n_str++;
      if (read_req_dmem === 1'b1) n_str++;
      if (n_str != 0) begin
         check("strobe_exclusive", n_str, 1);
         check("cpu_rst_during_access", cpu_rst, 1'b1);
      end
      if (write_to_imem === 1'b1) mon_event(EV_WI, addr_imem_host, data_imem_host);
      if (write_to_dmem === 1'b1) mon_event(EV_WD, addr_dmem_host, data_dmem_host);
      if (read_req_dmem === 1'b1) mon_event(EV_RQ, addr_dmem_host, '0);
      if (resp_valid === 1'b1 && resp_ready) mon_event(EV_RS, 0, resp_data);
      if (prev_stall && resp_valid === 1'b1) check("resp_stable", resp_data, prev_resp);
      prev_stall = (resp_valid === 1'b1) && !resp_ready;
      prev_resp  = resp_data;
   end

   // Stimulus helpers; all are entered and left just after a rising edge.
   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic send(input logic [31:0] w);
      bit acc;
      int n;
      acc = 1'b0;
      n = 0;
      cmd_valid = 1'b1;
      cmd_data  = w;
      while (!acc && n < 50) begin
         @(negedge clk);
         acc = cmd_ready;
         @(posedge clk);
         #1;
         n++;
      end
      cmd_valid = 1'b0;
      cmd_data  = $urandom;
      if (!acc) begin
         n_vec++;
         n_err++;
         $display("FAIL cmd_accept_timeout: got no cmd_ready expected accept of %h", w);
      end
   endtask

   function automatic logic [31:0] mk_hdr(input logic [1:0] op, input int unsigned len,
                                          input int unsigned addr);
      logic [31:0] h;
      logic [31:0] l;
      logic [31:0] a;
      h = $urandom;
      l = len;
      a = addr;
      h[31:30] = op;
      h[16+LEN_W-1:16] = l[LEN_W-1:0];
      h[IMEM_AW-1:0] = a[IMEM_AW-1:0];
      return h;
   endfunction

   task automatic do_run(input bit b);
      logic [31:0] h;
      h = $urandom;
      h[31:30] = 2'b11;
      h[0] = b;
      send(h);
      model_cpu_rst = ~b;
      check("run_cpu_rst", cpu_rst, model_cpu_rst);
      check("run_busy", busy, 1'b0);
   endtask

   task automatic do_load(input bit is_dmem, input int unsigned addr, input int unsigned len,
                          input int mingap, input int maxgap);
      logic [31:0] words [$];
      int unsigned a;
      ev_t e;
      for (int unsigned k = 0; k < len; k++) begin
         words.push_back(pend_words.size() != 0 ? pend_words.pop_front() : $urandom);
         a = is_dmem ? (addr + k) % DMEM_D : (addr + k) % IMEM_D;
         e.kind = is_dmem ? EV_WD : EV_WI;
         e.addr = a;
         e.data = words[k];
         exp_q.push_back(e);
         if (is_dmem) model_dmem[a] = words[k];
      end
      send(mk_hdr(is_dmem ? 2'b01 : 2'b00, len, addr));
      model_cpu_rst = 1'b1;
      check("load_hdr_cpu_rst", cpu_rst, 1'b1);
      check("load_hdr_busy", busy, len != 0);
      for (int unsigned k = 0; k < len; k++) begin
         if (maxgap > 0) idle($urandom_range(maxgap, mingap));
         send(words[k]);
      end
      check("load_done_busy", busy, 1'b0);
   endtask

   task automatic do_read(input int unsigned addr, input int unsigned len, input int bp_max,
                          input bit fixed_bp);
      int unsigned a;
      int bp;
      int n;
      bit seen;
      ev_t e;
      for (int unsigned k = 0; k < len; k++) begin
         a = (addr + k) % DMEM_D;
         e.kind = EV_RQ; e.addr = a; e.data = '0;
         exp_q.push_back(e);
         e.kind = EV_RS; e.addr = 0; e.data = model_dmem[a];
         exp_q.push_back(e);
      end
      send(mk_hdr(2'b10, len, addr));
      model_cpu_rst = 1'b1;
      check("read_hdr_cpu_rst", cpu_rst, 1'b1);
      check("read_hdr_busy", busy, len != 0);
      for (int unsigned k = 0; k < len; k++) begin
         a = (addr + k) % DMEM_D;
         check("read_cmd_ready", cmd_ready, 1'b0);
         resp_ready = 1'b0;
         bp = fixed_bp ? bp_max : $urandom_range(bp_max, 0);
         idle(bp);
         if (bp >= LAT + 4) begin
            check("read_stalled_valid", resp_valid, 1'b1);
            check("read_stalled_data", resp_data, model_dmem[a]);
            check("read_stalled_cmd_ready", cmd_ready, 1'b0);
         end
         resp_ready = 1'b1;
         seen = 1'b0;
         n = 0;
         while (!seen && n < 50) begin
            @(negedge clk);
            seen = (resp_valid === 1'b1);
            @(posedge clk);
            #1;
            n++;
         end
         resp_ready = 1'b0;
         if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL resp_timeout: got no resp_valid expected word for addr %0d", a);
         end
      end
      check("read_done_busy", busy, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected run to complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int unsigned a;
      int unsigned len;
      int sel;
      for (int i = 0; i < DMEM_D; i++) model_dmem[i] = '0;
      model_cpu_rst = 1'b1;
      rst        = 1'b1;
      cmd_valid  = 1'b0;
      cmd_data   = '0;
      resp_ready = 1'b0;
      idle(2);

      check("rst_cpu_rst", cpu_rst, 1'b1);
      check("rst_cmd_ready", cmd_ready, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_strobes", {write_to_imem, write_to_dmem, read_req_dmem}, 3'b000);
      check("rst_resp_valid", resp_valid, 1'b0);
      check("rst_resp_data", resp_data, '0);
      check("rst_addr_imem", addr_imem_host, '0);
      check("rst_addr_dmem", addr_dmem_host, '0);
      rst = 1'b0;
      #1;
      check("post_rst_cmd_ready", cmd_ready, 1'b1);

      send(32'hC000_0001);
      model_cpu_rst = 1'b0;
      check("run_release_cpu_rst", cpu_rst, 1'b0);
      check("run_release_busy", busy, 1'b0);

      // imem burst across the 511 -> 0 wrap
      pend_words = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
      do_load(1'b0, 510, 3, 0, 0);
      idle(1);

      // dmem load then stalled readback
      pend_words = '{32'h1111_1111, 32'h2222_2222};
      do_load(1'b1, 4, 2, 0, 0);
      do_read(4, 2, 5, 1'b1);

      // zero-length header, then a load with a 3-cycle gap between words
      send(32'h4000_0010);
      check("zero_len_busy", busy, 1'b0);
      check("zero_len_cpu_rst", cpu_rst, 1'b1);
      idle(2);
      do_load(1'b1, 200, 2, 3, 3);

      // reset after the second word of a four-word imem burst
      do_run(1'b1);
      begin
         ev_t e;
         logic [31:0] w0;
         logic [31:0] w1;
         w0 = $urandom;
         w1 = $urandom;
         e.kind = EV_WI; e.addr = 100; e.data = w0; exp_q.push_back(e);
         e.kind = EV_WI; e.addr = 101; e.data = w1; exp_q.push_back(e);
         send(mk_hdr(2'b00, 4, 100));
         send(w0);
         send(w1);
         rst = 1'b1;
         idle(1);
         rst = 1'b0;
         model_cpu_rst = 1'b1;
         check("midrst_busy", busy, 1'b0);
         check("midrst_cpu_rst", cpu_rst, 1'b1);
         idle(3);
         check("midrst_idle_busy", busy, 1'b0);
      end
      do_load(1'b0, 300, 2, 0, 1);

      // randomized mix including address wrap and lengths beyond small bursts
      for (int it = 0; it < 60; it++) begin
         sel = $urandom_range(3, 0);
         len = ($urandom_range(3, 0) == 0) ? $urandom_range(12, 0) : $urandom_range(4, 0);
         case ($urandom_range(3, 0))
            0:       a = IMEM_D - 2;
            1:       a = DMEM_D - 1;
            default: a = $urandom_range(IMEM_D - 1, 0);
         endcase
         case (sel)
            0: do_load(1'b0, a, len, 0, 2);
            1: do_load(1'b1, a, len, 0, 2);
            2: do_read(a % DMEM_D, len, 3, 1'b0);
            default: do_run($urandom_range(1, 0) == 1);
         endcase
         idle($urandom_range(2, 0));
      end

      idle(5);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
